change_dispenser: RTL and testbench

- Sequences a refund amount into individual coin-eject commands for three coin tubes (5, 2, 1 units), greedy largest-first.
- Each eject is timed with a hold period and a gap period so the solenoids and the mechanism can settle.
- Sits between fsm_controller (change_due, change_returning) and the board's eject outputs; reports progress, completion and shortfall back to the controller.

---
 rtl/change_dispenser_if.sv | 27 ++
 rtl/change_dispenser.sv | 124 ++++++++++++
 tb/tb_change_dispenser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vend controller and the change dispenser.
interface change_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic       have5;
    logic       have2;
    logic       have1;
    logic       busy;
    logic       done;
    logic       eject5;
    logic       eject2;
    logic       eject1;
    logic [7:0] remaining;
    logic [7:0] coins_out;
    logic       error;
    logic [7:0] shortfall;

    modport master (
        output start, amount, have5, have2, have1,
        input  busy, done, eject5, eject2, eject1, remaining, coins_out, error, shortfall
    );

    modport slave (
        input  start, amount, have5, have2, have1,
        output busy, done, eject5, eject2, eject1, remaining, coins_out, error, shortfall
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change dispenser: one timed solenoid pulse per coin, then a settle gap.
module change_dispenser #(
    parameter int EJECT_ON  = 25000,
    parameter int EJECT_GAP = 25000
) (
    input  logic            clk,
    input  logic            rst,
    change_dispenser_if.slave bus
);
    localparam int CMAX = (EJECT_ON > EJECT_GAP) ? EJECT_ON : EJECT_GAP;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ej_q, ej_d;          // {eject5, eject2, eject1}
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [7:0]    coins_out_q, coins_out_d;
    logic          error_q, error_d;
    logic [7:0]    shortfall_q, shortfall_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ej_d        = '0;
        remaining_d = remaining_q;
        coins_out_d = coins_out_q;
        error_d     = error_q;
        shortfall_d = shortfall_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SELECT;
                    remaining_d = bus.amount;
                    coins_out_d = '0;
                    error_d     = 1'b0;
                    shortfall_d = '0;
                end
            end
            SELECT: begin
                cnt_d = CW'(EJECT_ON - 1);
                if (remaining_q == 8'd0) begin
                    state_d = DONE;
                end else if (remaining_q >= 8'd5 && bus.have5) begin
                    state_d     = EJECT;
                    ej_d        = 3'b100;
                    remaining_d = remaining_q - 8'd5;
                    coins_out_d = coins_out_q + 8'd1;
                end else if (remaining_q >= 8'd2 && bus.have2) begin
                    state_d     = EJECT;
                    ej_d        = 3'b010;
                    remaining_d = remaining_q - 8'd2;
                    coins_out_d = coins_out_q + 8'd1;
                end else if (bus.have1) begin
                    state_d     = EJECT;
                    ej_d        = 3'b001;
                    remaining_d = remaining_q - 8'd1;
                    coins_out_d = coins_out_q + 8'd1;
                end else begin
                    // Nothing payable from the tubes left: report what is still owed.
                    state_d     = DONE;
                    error_d     = 1'b1;
                    shortfall_d = remaining_q;
                end
            end
            EJECT: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(EJECT_GAP - 1);
                end else begin
                    ej_d  = ej_q;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = SELECT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ej_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            coins_out_q <= '0;
            error_q     <= 1'b0;
            shortfall_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ej_q        <= ej_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            coins_out_q <= coins_out_d;
            error_q     <= error_d;
            shortfall_q <= shortfall_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.eject5    = ej_q[2];
    assign bus.eject2    = ej_q[1];
    assign bus.eject1    = ej_q[0];
    assign bus.remaining = remaining_q;
    assign bus.coins_out = coins_out_q;
    assign bus.error     = error_q;
    assign bus.shortfall = shortfall_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser with a greedy change-making reference model.
module tb_change_dispenser;
    localparam int ON  = 4;
    localparam int GP  = 3;
    localparam int P   = 1 + ON + GP;

    typedef struct { int coin; int cyc; int rem; } ej_exp_t;
    typedef struct { int cyc; int coins; int rem; int err; int sh; } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ej_exp_t   ej_q[$];
    done_exp_t done_q[$];
    logic [2:0] sched [0:256];

    change_dispenser_if bus();

    change_dispenser #(.EJECT_ON(ON), .EJECT_GAP(GP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows an eject start or a done pulse.
    logic [2:0] prev_ej = '0;
    int         ej_len = 0;
    logic       prev_done = 1'b0;
    always @(negedge clk) begin
        logic [2:0] ej;
        int         coin;
        ej_exp_t    e;
        done_exp_t  d;
        if (rst) begin
            prev_ej = '0; ej_len = 0; prev_done = 1'b0;
        end else begin
            ej = {bus.eject5, bus.eject2, bus.eject1};
            chk("eject_onehot", int'($countones(ej) <= 1), 1);
            coin = (ej == 3'b100) ? 5 : (ej == 3'b010) ? 2 : (ej == 3'b001) ? 1 : 0;
            if (ej != 3'b000 && prev_ej == 3'b000) begin
                if (ej_q.size() == 0) chk("unexpected_eject", 1, 0);
                else begin
                    e = ej_q.pop_front();
                    chk("eject_coin", coin, e.coin);
                    chk("eject_cycle", cyc, e.cyc);
                    chk("eject_remaining", int'(bus.remaining), e.rem);
                end
            end
            if (ej != 3'b000) ej_len++;
            if (ej == 3'b000 && prev_ej != 3'b000) begin
                chk("eject_len", ej_len, ON);
                ej_len = 0;
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_busy", int'(bus.busy), 1);
                    chk("done_coins", int'(bus.coins_out), d.coins);
                    chk("done_remaining", int'(bus.remaining), d.rem);
                    chk("done_error", int'(bus.error), d.err);
                    chk("done_shortfall", int'(bus.shortfall), d.sh);
                end
            end
            if (prev_done) chk("busy_after_done", int'(bus.busy), 0);
            prev_ej = ej;
            prev_done = bus.done;
        end
    end

    task automatic set_have(input logic [2:0] h);
        bus.have5 = h[2]; bus.have2 = h[1]; bus.have1 = h[0];
    endtask

    task automatic fill_sched(input logic [2:0] h);
        for (int i = 0; i <= 256; i++) sched[i] = h;
    endtask

    // Issues one request; sched[k] is the tube state seen by the k-th selection.
    task automatic run_req(input logic [7:0] amt, input bit junk);
        int c0, n, done_off, c, rem, err, sh, hold;
        logic [2:0] h;
        @(posedge clk); #1;
        c0 = cyc;
        set_have(sched[0]);
        bus.start = 1'b1;
        bus.amount = amt;
        // Greedy change-making: largest available coin not exceeding what is owed.
        rem = int'(amt); n = 0; err = 0; sh = 0;
        while (rem > 0) begin
            h = sched[n];
            if (rem >= 5 && h[2])      c = 5;
            else if (rem >= 2 && h[1]) c = 2;
            else if (h[0])             c = 1;
            else                       c = 0;
            if (c == 0) begin err = 1; sh = rem; break; end
            rem -= c;
            ej_q.push_back('{coin: c, cyc: c0 + 2 + n * P, rem: rem});
            n++;
        end
        done_off = 2 + n * P;
        done_q.push_back('{cyc: c0 + done_off, coins: n, rem: rem, err: err, sh: sh});
        for (int t = 1; t <= done_off + 1; t++) begin
            @(posedge clk); #1;
            bus.start = junk && (t % P == 4) && (t < done_off);
            bus.amount = 8'($urandom);
            if (t % P == 3) set_have(3'($urandom));
            if (t % P == 0) set_have(sched[t / P]);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_seen", done_q.size(), 0);
        chk("ejects_all_seen", ej_q.size(), 0);
        hold = $urandom_range(0, 3);
        repeat (hold) begin @(posedge clk); #1; bus.amount = 8'($urandom); end
        chk("hold_remaining", int'(bus.remaining), rem);
        chk("hold_coins", int'(bus.coins_out), n);
        chk("hold_error", int'(bus.error), err);
        chk("hold_shortfall", int'(bus.shortfall), sh);
        chk("idle_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int c0;
        bus.start = 1'b0; bus.amount = '0;
        set_have(3'b111);
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ejects", int'({bus.eject5, bus.eject2, bus.eject1}), 0);
        chk("rst_remaining", int'(bus.remaining), 0);
        chk("rst_coins", int'(bus.coins_out), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_shortfall", int'(bus.shortfall), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fill_sched(3'b111); run_req(8'd8, 1'b0);
        fill_sched(3'b111); run_req(8'd0, 1'b0);
        fill_sched(3'b101); run_req(8'd4, 1'b0);
        fill_sched(3'b100); run_req(8'd7, 1'b0);
        fill_sched(3'b111); run_req(8'd12, 1'b1);
        // Five tube runs dry after the first coin: fall back to 2s.
        fill_sched(3'b011); sched[0] = 3'b111; run_req(8'd11, 1'b0);
        fill_sched(3'b111); run_req(8'd255, 1'b0);

        // Reset in the middle of the first eject pulse.
        fill_sched(3'b111);
        @(posedge clk); #1;
        c0 = cyc;
        bus.start = 1'b1; bus.amount = 8'd12;
        ej_q.push_back('{coin: 5, cyc: c0 + 2, rem: 7});
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_rst_eject5", int'(bus.eject5), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_eject5", int'(bus.eject5), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_remaining", int'(bus.remaining), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_flush_ej", ej_q.size(), 0);
        ej_q.delete();
        done_q.delete();
        run_req(8'd1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i <= 256; i++)
                sched[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            run_req(8'($urandom_range(0, 40)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
